// File: rtl/gcd_scheduler.sv
// Round-robin front end sharing one iterative GCD engine among NUM_REQ clients.
// Ports: req_* (per-client request), rsp_* (tagged response), eng_* (engine control).
module gcd_scheduler #(
  parameter int WIDTH   = 40,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_err,
  output logic                     eng_start,
  output logic [WIDTH-1:0]         eng_x,
  output logic [WIDTH-1:0]         eng_y,
  output logic                     eng_reset,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_result
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] LAST_RST =
    ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              erst_q, erst_d;

  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   idx;
  logic              found;
  logic [WIDTH-1:0]  sel_x;
  logic [WIDTH-1:0]  sel_y;

  // Rotating priority: first valid requester after last_q wins.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == ID_W'(i)) begin
        sel_x = req_x[i*WIDTH +: WIDTH];
        sel_y = req_y[i*WIDTH +: WIDTH];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE && found)
                   ? (NUM_REQ'(1) << pick)
                   : '0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    erst_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          last_d = pick;
          id_d   = pick;
          x_d    = sel_x;
          y_d    = sel_y;
          // gcd(0,v)=v and gcd(0,0)=0 need no engine
          if (sel_x == '0 || sel_y == '0) begin
            res_d   = sel_x | sel_y;
            err_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over the watchdog
        if (eng_done) begin
          res_d   = eng_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_MAX) begin
          res_d   = '0;
          err_d   = 1'b1;
          erst_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      last_q  <= LAST_RST;
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      erst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      erst_q  <= erst_d;
    end
  end

  assign rsp_valid  = (state_q == S_RESP);
  assign eng_start  = (state_q == S_ISSUE);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign eng_x      = x_q;
  assign eng_y      = y_q;
  // reset term makes the engine reset follow rst asynchronously
  assign eng_reset  = erst_q | ~reset;

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler with a response scoreboard.
// Engine done/result are driven by hand at exact cycles.
module tb_gcd_scheduler;

  localparam int W  = 40;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  res;
    logic          err;
  } exp_t;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_err;
  logic           eng_start;
  logic [W-1:0]   eng_x;
  logic [W-1:0]   eng_y;
  logic           eng_reset;
  logic           eng_done;
  logic [W-1:0]   eng_result;

  exp_t sb[$];
  int   n_checks;
  int   n_err;

  gcd_scheduler #(
    .WIDTH(W),
    .NUM_REQ(N),
    .TIMEOUT(TO),
    .ID_W(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_x(req_x),
    .req_y(req_y),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_result(rsp_result),
    .rsp_err(rsp_err),
    .eng_start(eng_start),
    .eng_x(eng_x),
    .eng_y(eng_y),
    .eng_reset(eng_reset),
    .eng_done(eng_done),
    .eng_result(eng_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  // Present a request in IDLE, expect it granted now.
  task automatic grant(input int id,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input logic [W-1:0] r,
                       input logic e,
                       input bit keep);
    exp_t ex;
    req_valid[id] = 1'b1;
    req_x[id*W +: W] = x;
    req_y[id*W +: W] = y;
    #1;
    chk("grant", 64'(req_ready), 64'(1) << id);
    ex.id  = IW'(id);
    ex.res = r;
    ex.err = e;
    sb.push_back(ex);
    tick();
    if (!keep) req_valid[id] = 1'b0;
  endtask

  // Called in the ISSUE cycle; done comes lat-1 cycles later.
  task automatic engine(input int lat,
                        input logic [W-1:0] ex,
                        input logic [W-1:0] ey,
                        input logic [W-1:0] res);
    chk("eng_start", 64'(eng_start), 1);
    chk("eng_x", 64'(eng_x), 64'(ex));
    chk("eng_y", 64'(eng_y), 64'(ey));
    repeat (lat - 1) begin
      tick();
      chk("start_once", 64'(eng_start), 0);
      chk("x_stable", 64'(eng_x), 64'(ex));
      chk("no_early_rsp", 64'(rsp_valid), 0);
    end
    eng_done   = 1'b1;
    eng_result = res;
    tick();
    eng_done   = 1'b0;
    eng_result = '0;
  endtask

  task automatic accept(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 64'(rsp_valid), 1);
    n_checks++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed empty expected entry",
             tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_id"}, 64'(rsp_id), 64'(e.id));
      chk({tag, "_res"}, 64'(rsp_result), 64'(e.res));
      chk({tag, "_err"}, 64'(rsp_err), 64'(e.err));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, 64'(rsp_valid), 0);
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    reset      = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    rsp_ready  = 1'b0;
    eng_done   = 1'b0;
    eng_result = '0;

    // reset values
    #1 reset = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_eng_start", 64'(eng_start), 0);
    chk("rst_eng_reset", 64'(eng_reset), 1);
    chk("rst_rsp_result", 64'(rsp_result), 0);
    chk("rst_rsp_err", 64'(rsp_err), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("run_eng_reset", 64'(eng_reset), 0);

    // single request through the engine
    grant(0, 12, 15, 3, 1'b0, 1'b0);
    engine(5, 12, 15, 3);
    chk("single_eng_reset", 64'(eng_reset), 0);
    accept("single");

    // zero-operand shortcuts
    grant(2, 0, 42, 42, 1'b0, 1'b0);
    chk("zs_no_start", 64'(eng_start), 0);
    accept("zero42");
    grant(1, 0, 0, 0, 1'b0, 1'b0);
    chk("zz_no_start", 64'(eng_start), 0);
    accept("zero00");

    // backpressure; requester 3 waits behind 2
    req_valid[3] = 1'b1;
    req_x[3*W +: W] = '0;
    req_y[3*W +: W] = W'(9);
    grant(2, 21, 14, 7, 1'b0, 1'b0);
    engine(3, 21, 14, 7);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rsp_valid), 1);
      chk("bp_id", 64'(rsp_id), 2);
      chk("bp_res", 64'(rsp_result), 7);
      chk("bp_err", 64'(rsp_err), 0);
      chk("bp_no_grant", 64'(req_ready), 0);
      tick();
    end
    accept("bp");
    grant(3, 0, 9, 9, 1'b0, 1'b0);
    accept("bp_next");

    // round robin with everyone valid
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1;
      req_x[i*W +: W] = '0;
      req_y[i*W +: W] = W'(16 + i);
    end
    for (int k = 0; k < 5; k++) begin
      grant(k % N, 0, W'(16 + (k % N)),
            W'(16 + (k % N)), 1'b0, 1'b1);
      accept("rr");
    end
    req_valid = '0;

    // watchdog timeout
    grant(1, 6, 4, 0, 1'b1, 1'b0);
    chk("to_start", 64'(eng_start), 1);
    for (int i = 0; i < TO; i++) begin
      tick();
      chk("to_wait", 64'(rsp_valid), 0);
      chk("to_no_ereset", 64'(eng_reset), 0);
    end
    tick();
    chk("to_rsp", 64'(rsp_valid), 1);
    chk("to_ereset", 64'(eng_reset), 1);
    tick();
    chk("to_ereset_once", 64'(eng_reset), 0);
    accept("timeout");

    // done exactly on the threshold cycle
    grant(2, 9, 6, 3, 1'b0, 1'b0);
    engine(TO + 1, 9, 6, 3);
    chk("th_ereset", 64'(eng_reset), 0);
    accept("thresh");

    // reset in the middle of WAIT
    grant(0, 8, 12, 4, 1'b0, 1'b0);
    tick();
    tick();
    #1 reset = 1'b0;
    #1;
    chk("mr_eng_reset", 64'(eng_reset), 1);
    chk("mr_rsp_valid", 64'(rsp_valid), 0);
    chk("mr_eng_start", 64'(eng_start), 0);
    chk("mr_eng_x", 64'(eng_x), 0);
    chk("mr_req_ready", 64'(req_ready), 0);
    sb.delete();
    tick();
    reset = 1'b1;
    eng_done   = 1'b1;
    eng_result = W'(99);
    tick();
    eng_done   = 1'b0;
    eng_result = '0;
    chk("stray_no_rsp", 64'(rsp_valid), 0);
    chk("stray_no_start", 64'(eng_start), 0);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1;
      req_x[i*W +: W] = '0;
      req_y[i*W +: W] = W'(1 + i);
    end
    grant(0, 0, 1, 1, 1'b0, 1'b1);
    req_valid = '0;
    accept("post_rst");

    chk("sb_drained", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
